// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the on-chip SPI configuration master.
package spi_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } spi_state_t;

   localparam int   FRAME_W   = 16;
   localparam logic SPI_WRITE = 1'b1;

   localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

   function automatic logic [FRAME_W-1:0] make_frame(input logic [6:0] addr, input logic [7:0] data);
      return {SPI_WRITE, addr, data};
   endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last accepted port.
module spi_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_grant
);

   logic r_last;

   always_comb begin
      o_grant = 2'b00;
      case (i_req)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

   // Reset value 1 makes port 0 the winner of the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (i_accept) begin
         r_last <= o_grant[1];
      end
   end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI master that serialises arbitrated register writes as 16-bit frames.
// Handshake: reqN_ready is high in IDLE (outside the done cycle) when port N holds the grant; a write transfers when valid && ready.
module spi_cfg_master
   import spi_cfg_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [6:0] req0_addr,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [6:0] req1_addr,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       busy,
   output logic       done,
   output logic       done_id,
   output logic       sclk,
   output logic       ncs,
   output logic       sdi,
   output logic [2:0] o_dbg_state
);

   if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("spi_cfg_master: CLK_DIV must be in 3..255");
   end
   if (CS_GAP < 4 || CS_GAP > 65535) begin : g_bad_cs_gap
      $error("spi_cfg_master: CS_GAP must be in 4..65535");
   end

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

   spi_state_t         r_state, w_state_nxt;
   logic [15:0]        r_cnt, w_cnt_nxt;
   logic [3:0]         r_bit, w_bit_nxt;
   logic [FRAME_W-1:0] r_frame, w_frame_nxt;
   logic               r_id, w_id_nxt;
   logic               r_sclk, r_ncs, r_sdi, r_busy, r_done, r_done_id;
   logic               w_sclk_nxt, w_ncs_nxt, w_sdi_nxt, w_busy_nxt, w_done_nxt;
   logic [1:0]         w_grant;
   logic               w_can_accept, w_accept, w_div_end, w_gap_end;

   spi_rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    ({req1_valid, req0_valid}),
      .i_accept (w_accept),
      .o_grant  (w_grant)
   );

   // The done cycle is idle but closed, so back-to-back frames are spaced by one extra cycle.
   assign w_can_accept = (r_state == ST_IDLE) && !r_done;
   assign req0_ready   = w_can_accept && w_grant[0];
   assign req1_ready   = w_can_accept && w_grant[1];
   assign w_accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign w_div_end    = (r_cnt == DIV_LAST);
   assign w_gap_end    = (r_cnt == GAP_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 16'd1;
      w_bit_nxt   = r_bit;
      w_frame_nxt = r_frame;
      w_id_nxt    = r_id;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_accept) begin
               w_state_nxt = ST_SETUP;
               w_bit_nxt   = '0;
               w_id_nxt    = w_grant[1];
               w_frame_nxt = w_grant[1] ? make_frame(req1_addr, req1_data)
                                        : make_frame(req0_addr, req0_data);
            end
         end
         ST_SETUP: begin
            if (w_div_end) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = '0;
            end
         end
         ST_HIGH: begin
            if (w_div_end) begin
               w_cnt_nxt = '0;
               if (r_bit == 4'd15) begin
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_state_nxt = ST_LOW;
                  w_bit_nxt   = r_bit + 4'd1;
                  w_frame_nxt = {r_frame[FRAME_W-2:0], 1'b0};
               end
            end
         end
         ST_LOW: begin
            if (w_div_end) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = '0;
            end
         end
         ST_HOLD: begin
            if (w_div_end) begin
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = '0;
            end
         end
         ST_GAP: begin
            if (w_gap_end) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      // Pins are registered from the next state so they switch with the state itself.
      w_sclk_nxt = (w_state_nxt == ST_HIGH);
      w_ncs_nxt  = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GAP);
      w_sdi_nxt  = w_ncs_nxt ? 1'b0 : w_frame_nxt[FRAME_W-1];
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_frame   <= '0;
         r_id      <= 1'b0;
         r_sclk    <= 1'b0;
         r_ncs     <= 1'b1;
         r_sdi     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit     <= w_bit_nxt;
         r_frame   <= w_frame_nxt;
         r_id      <= w_id_nxt;
         r_sclk    <= w_sclk_nxt;
         r_ncs     <= w_ncs_nxt;
         r_sdi     <= w_sdi_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_done_id <= w_done_nxt ? r_id : r_done_id;
      end
   end

   assign sclk        = r_sclk;
   assign ncs         = r_ncs;
   assign sdi         = r_sdi;
   assign busy        = r_busy;
   assign done        = r_done;
   assign done_id     = r_done_id;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: two instances (default and fastest pacing) with a peripheral model each.
module tb_spi_cfg_master;
   import spi_cfg_pkg::*;

   typedef struct { int port; logic [6:0] addr; logic [7:0] data; } req_t;
   typedef struct { int port; int cyc; } ev_t;
   typedef struct {
      int port; logic [6:0] addr; logic [7:0] data;
      logic [15:0] exp_frame; bit mapped; logic [7:0] exp_reg;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       req0_valid[2], req1_valid[2];
   logic [6:0] req0_addr[2], req1_addr[2];
   logic [7:0] req0_data[2], req1_data[2];
   logic       req0_ready[2], req1_ready[2];
   logic       busy[2], done[2], done_id[2], sclk[2], ncs[2], sdi[2];
   logic [2:0] dbg_state[2];

   spi_cfg_master #(.CLK_DIV(4), .CS_GAP(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid[0]), .req0_addr(req0_addr[0]), .req0_data(req0_data[0]), .req0_ready(req0_ready[0]),
      .req1_valid(req1_valid[0]), .req1_addr(req1_addr[0]), .req1_data(req1_data[0]), .req1_ready(req1_ready[0]),
      .busy(busy[0]), .done(done[0]), .done_id(done_id[0]),
      .sclk(sclk[0]), .ncs(ncs[0]), .sdi(sdi[0]), .o_dbg_state(dbg_state[0])
   );

   spi_cfg_master #(.CLK_DIV(3), .CS_GAP(4)) dut_fast (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid[1]), .req0_addr(req0_addr[1]), .req0_data(req0_data[1]), .req0_ready(req0_ready[1]),
      .req1_valid(req1_valid[1]), .req1_addr(req1_addr[1]), .req1_data(req1_data[1]), .req1_ready(req1_ready[1]),
      .busy(busy[1]), .done(done[1]), .done_id(done_id[1]),
      .sclk(sclk[1]), .ncs(ncs[1]), .sdi(sdi[1]), .o_dbg_state(dbg_state[1])
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Request queues indexed inst*2+port; head is presented until accepted.
   req_t pq[4][$];

   // Peripheral model and event logs, sampled on the falling clk edge.
   logic [15:0] sh[2], last_frame[2];
   int          edges[2], last_edges[2], low_run[2], last_low[2], viol[2], dual_ready[2];
   logic [7:0]  regs[2][5];
   logic        p_sclk[2], p_ncs[2], p_sdi[2];
   ev_t         acc_log[2][$];
   ev_t         done_log[2][$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_done(input int g, input int n, input int budget);
      int k = 0;
      while (done_log[g].size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk($sformatf("done_seen_i%0d_n%0d", g, n), 32'(done_log[g].size() >= n), 32'd1);
   endtask

   function automatic logic [39:0] pack_regs(input int g);
      return {regs[g][4], regs[g][3], regs[g][2], regs[g][1], regs[g][0]};
   endfunction

   initial begin
      for (int g = 0; g < 2; g++) begin
         sh[g] = '0; last_frame[g] = '0; edges[g] = 0; last_edges[g] = 0;
         low_run[g] = 0; last_low[g] = 0; viol[g] = 0; dual_ready[g] = 0;
         p_sclk[g] = 1'b0; p_ncs[g] = 1'b1; p_sdi[g] = 1'b0;
         for (int r = 0; r < 5; r++) regs[g][r] = 8'h00;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
               edges[g] = 0; low_run[g] = 0; sh[g] = '0;
               p_ncs[g] = 1'b1; p_sclk[g] = 1'b0; p_sdi[g] = 1'b0;
               for (int r = 0; r < 5; r++) regs[g][r] = 8'h00;
            end else begin
               if (!ncs[g]) begin
                  low_run[g]++;
               end else if (!p_ncs[g]) begin
                  last_low[g] = low_run[g]; low_run[g] = 0;
                  last_frame[g] = sh[g]; last_edges[g] = edges[g];
                  if (edges[g] == 16 && sh[g][15] && sh[g][14:8] < 7'd5)
                     regs[g][sh[g][14:8]] = sh[g][7:0];
                  edges[g] = 0;
               end
               if (sclk[g] && !p_sclk[g] && !ncs[g]) begin
                  sh[g] = {sh[g][14:0], sdi[g]};
                  edges[g]++;
               end
               if (sclk[g] && p_sclk[g] && (sdi[g] != p_sdi[g])) viol[g]++;
               if (req0_ready[g] && req1_ready[g]) dual_ready[g]++;
               if (req0_valid[g] && req0_ready[g]) acc_log[g].push_back('{0, cyc});
               if (req1_valid[g] && req1_ready[g]) acc_log[g].push_back('{1, cyc});
               if (done[g]) done_log[g].push_back('{int'(done_id[g]), cyc});
               p_ncs[g] = ncs[g]; p_sclk[g] = sclk[g]; p_sdi[g] = sdi[g];
            end
         end
      end
   end

   // Driver: present queue heads, pop when the handshake completed.
   initial begin
      bit acc[4];
      for (int g = 0; g < 2; g++) begin
         req0_valid[g] = 1'b0; req0_addr[g] = '0; req0_data[g] = '0;
         req1_valid[g] = 1'b0; req1_addr[g] = '0; req1_data[g] = '0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            acc[g*2]   = req0_valid[g] && req0_ready[g];
            acc[g*2+1] = req1_valid[g] && req1_ready[g];
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            if (i % 2 == 0) begin
               req0_valid[i/2] = (pq[i].size() > 0);
               if (pq[i].size() > 0) begin req0_addr[i/2] = pq[i][0].addr; req0_data[i/2] = pq[i][0].data; end
            end else begin
               req1_valid[i/2] = (pq[i].size() > 0);
               if (pq[i].size() > 0) begin req1_addr[i/2] = pq[i][0].addr; req1_data[i/2] = pq[i][0].data; end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs[5];
      int          na, nd, bad, k;
      logic [39:0] snap;
      logic [7:0]  exp_r[5];

      vecs[0] = '{0, ADDR_PWM_DUTY,    8'hA5, 16'h84A5, 1'b1, 8'hA5};
      vecs[1] = '{1, ADDR_EN_PWM_7_0,  8'h3C, 16'h823C, 1'b1, 8'h3C};
      vecs[2] = '{0, 7'h07,            8'h55, 16'h8755, 1'b0, 8'h00};
      vecs[3] = '{1, ADDR_EN_OUT_15_8, 8'h5A, 16'h815A, 1'b1, 8'h5A};
      vecs[4] = '{1, ADDR_EN_OUT_7_0,  8'h00, 16'h8000, 1'b1, 8'h00};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_sclk",    sclk[0],    0);
      chk("rst_ncs",     ncs[0],     1);
      chk("rst_sdi",     sdi[0],     0);
      chk("rst_busy",    busy[0],    0);
      chk("rst_done",    done[0],    0);
      chk("rst_done_id", done_id[0], 0);
      chk("rst_ncs_fast", ncs[1],    1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single writes through the default-pacing instance.
      for (int i = 0; i < 5; i++) begin
         na = acc_log[0].size();
         nd = done_log[0].size();
         snap = pack_regs(0);
         pq[vecs[i].port].push_back('{vecs[i].port, vecs[i].addr, vecs[i].data});
         wait_done(0, nd + 1, 400);
         chk($sformatf("vec%0d_accept_port", i), acc_log[0][na].port, vecs[i].port);
         chk($sformatf("vec%0d_done_id", i), done_log[0][nd].port, vecs[i].port);
         chk($sformatf("vec%0d_latency", i), done_log[0][nd].cyc - acc_log[0][na].cyc, 141);
         chk($sformatf("vec%0d_frame", i), last_frame[0], vecs[i].exp_frame);
         chk($sformatf("vec%0d_sclk_edges", i), last_edges[0], 16);
         chk($sformatf("vec%0d_ncs_low", i), last_low[0], 132);
         chk($sformatf("vec%0d_busy_after_done", i), busy[0], 0);
         if (vecs[i].mapped)
            chk($sformatf("vec%0d_reg", i), regs[0][vecs[i].addr], vecs[i].exp_reg);
         else
            chk($sformatf("vec%0d_regs_unchanged", i), pack_regs(0), snap);
      end

      // Both ports valid in the same cycle.
      na = acc_log[0].size();
      nd = done_log[0].size();
      pq[0].push_back('{0, ADDR_EN_OUT_7_0, 8'hFF});
      pq[1].push_back('{1, ADDR_EN_OUT_15_8, 8'h0F});
      wait_done(0, nd + 1, 400);
      chk("tie_first_id", done_log[0][nd].port, 0);
      chk("tie_first_reg0", regs[0][0], 8'hFF);
      chk("tie_first_reg1_old", regs[0][1], 8'h5A);
      wait_done(0, nd + 2, 400);
      chk("tie_second_id", done_log[0][nd+1].port, 1);
      chk("tie_second_reg1", regs[0][1], 8'h0F);
      chk("tie_accept_order", {acc_log[0][na].port[0], acc_log[0][na+1].port[0]}, 2'b01);
      chk("tie_spacing", acc_log[0][na+1].cyc - acc_log[0][na].cyc, 142);
      chk("tie_single_ready", dual_ready[0], 0);

      // Port 0 continuously valid, port 1 arrives mid-transaction.
      na = acc_log[0].size();
      nd = done_log[0].size();
      pq[0].push_back('{0, ADDR_EN_PWM_15_8, 8'h11});
      pq[0].push_back('{0, ADDR_EN_PWM_15_8, 8'h22});
      k = 0;
      while (acc_log[0].size() == na && k < 50) begin @(negedge clk); k++; end
      repeat (40) @(negedge clk);
      pq[1].push_back('{1, ADDR_PWM_DUTY, 8'h77});
      wait_done(0, nd + 3, 700);
      chk("rr_order", {acc_log[0][na].port[0], acc_log[0][na+1].port[0], acc_log[0][na+2].port[0]}, 3'b010);
      chk("rr_spacing_1", acc_log[0][na+1].cyc - acc_log[0][na].cyc, 142);
      chk("rr_spacing_2", acc_log[0][na+2].cyc - acc_log[0][na+1].cyc, 142);
      chk("rr_reg3", regs[0][3], 8'h22);
      chk("rr_reg4", regs[0][4], 8'h77);

      // Reset at the 8th sclk rising edge of a frame.
      nd = done_log[0].size();
      pq[0].push_back('{0, ADDR_EN_OUT_7_0, 8'h99});
      k = 0;
      while (edges[0] < 8 && k < 300) begin @(negedge clk); k++; end
      chk("rst_mid_edge8", edges[0], 8);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ncs",  ncs[0],  1);
      chk("rst_mid_sclk", sclk[0], 0);
      chk("rst_mid_busy", busy[0], 0);
      repeat (3) @(negedge clk);
      chk("rst_mid_done", done[0], 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("rst_mid_no_done", done_log[0].size(), nd);
      chk("rst_mid_busy_idle", busy[0], 0);
      na = acc_log[0].size();
      pq[0].push_back('{0, ADDR_EN_PWM_7_0, 8'h3C});
      wait_done(0, nd + 1, 400);
      chk("post_rst_frame", last_frame[0], 16'h823C);
      chk("post_rst_reg2", regs[0][2], 8'h3C);
      chk("post_rst_reg0", regs[0][0], 8'h00);
      chk("post_rst_done_id", done_log[0][nd].port, 0);
      chk("post_rst_latency", done_log[0][nd].cyc - acc_log[0][na].cyc, 141);

      // Fastest pacing: ten back-to-back writes alternating ports.
      na = acc_log[1].size();
      nd = done_log[1].size();
      for (int r = 0; r < 5; r++) exp_r[r] = 8'h00;
      for (int i = 0; i < 10; i++) begin
         logic [6:0] a;
         logic [7:0] d;
         a = 7'(i % 5);
         d = (a == 7'd4) ? 8'h80 : 8'(i * 16 + 3);
         exp_r[i % 5] = d;
         pq[2 + (i % 2)].push_back('{i % 2, a, d});
      end
      wait_done(1, nd + 10, 1500);
      for (int r = 0; r < 5; r++) chk($sformatf("fast_reg%0d", r), regs[1][r], exp_r[r]);
      bad = 0;
      for (int j = 0; j < 9; j++)
         if (acc_log[1][na+j+1].cyc - acc_log[1][na+j].cyc != 105) bad++;
      chk("fast_spacing_errors", bad, 0);
      chk("fast_accept_count", acc_log[1].size() - na, 10);
      chk("fast_latency", done_log[1][nd].cyc - acc_log[1][na].cyc, 104);
      chk("fast_ncs_low", last_low[1], 99);
      chk("fast_edges", last_edges[1], 16);
      chk("sdi_stable_while_high", viol[0] + viol[1], 0);
      chk("single_ready_overall", dual_ready[0] + dual_ready[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_cfg_master.md
# spi_cfg_master

On-chip SPI master that programs the SPI register peripheral (output-enable, PWM-enable and PWM duty-cycle registers) from internal logic rather than an external host. Two internal requesters submit register writes through valid/ready ports. A round-robin arbiter picks one, and a sequencer serialises it as a 16-bit write frame on sclk/ncs/sdi. Frame pacing respects the peripheral's 2-flop input synchronisers and its post-frame commit window.

## Interface
- CLK_DIV, default 4: sclk half-period in clk cycles; legal range 3–255, enforced by an elaboration-time check.
- CS_GAP, default 8: clk cycles ncs is held high between frames; legal range ≥4.
- clk  in  1  system clock; same clock domain as the peripheral.
- rst_n  in  1  reset, asynchronous, active-low; shared with the peripheral.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  7  register address (0x00–0x04 meaningful; others are sent unchanged).
- req0_data  in  8  register data.
- req0_ready  out  1  request 0 accepted this cycle.
- req1_valid / req1_addr / req1_data / req1_ready: same as port 0, for requester 1.
- busy  out  1  high from accept until the end of the CS_GAP phase.
- done  out  1  one-cycle pulse when a transaction's GAP phase completes.
- done_id  out  1  requester index of the transaction reported by done; valid while done is high.
- sclk  out  1  SPI clock; idles low.
- ncs  out  1  chip select, active-low; idles high.
- sdi  out  1  serial data to peripheral, MSB first.

## Operation
- Frame format: {1'b1 (write), addr[6:0], data[7:0]}, bit 15 sent first. Reads are not supported.
- Handshake: reqN_ready = (state==IDLE) && grant==N. ready is combinational from valid; a transfer occurs when valid && ready. Requesters hold valid, addr and data stable until accepted and must not drop valid before acceptance.
- Arbitration (round-robin):
  - One requester valid: it wins.
  - Both valid: the port not granted last wins.
  - Pointer resets to "last = 1", so port 0 wins the first tie.
  - The pointer updates only on acceptance.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP. Phase counter counts CLK_DIV (or CS_GAP) cycles; bit index 0–15.
  - IDLE: ncs=1, sclk=0, sdi=0. On acceptance, latch the frame and grant id, set bit index=0, go to SETUP.
  - SETUP: ncs=0, sclk=0, sdi=frame[15]; after CLK_DIV cycles go to HIGH.
  - HIGH: sclk=1 for CLK_DIV cycles. At exit: if bit index=15 go to HOLD; else increment the index and go to LOW.
  - LOW: sclk=0; sdi presents the next bit from the first LOW cycle; after CLK_DIV cycles go to HIGH.
  - HOLD: ncs=0, sclk=0 for CLK_DIV cycles, then go to GAP.
  - GAP: ncs=1, sdi=0 for CS_GAP cycles; pulse done and go to IDLE.
- sdi changes only while sclk is low. Exactly 16 sclk rising edges occur per frame.
- Requests arriving while busy stay pending; they are not queued internally.

## Timing
- All of sclk, ncs, sdi, busy, done and done_id are registered. Reset values: sclk=0, ncs=1, sdi=0, busy=0, done=0, done_id=0; arbiter pointer=1.
- The acceptance cycle is IDLE; ncs falls on the next clk edge.
- ncs is low for exactly 33·CLK_DIV cycles (SETUP + 16 HIGH + 15 LOW + HOLD).
- Accept-to-done: 1 + 33·CLK_DIV + CS_GAP cycles; 141 with defaults.
- Back-to-back: the next acceptance can occur in the IDLE cycle after done. Minimum request spacing is 2 + 33·CLK_DIV + CS_GAP cycles.
- Reset mid-frame: outputs go to idle immediately (async). The latched frame is dropped and never retransmitted, and no done pulse is issued.
- Simultaneous valid on both ports in IDLE: exactly one ready is asserted in that cycle.

## Structure
- Package spi_cfg_pkg holds:
  - FSM state enum.
  - FRAME_W=16 and SPI_WRITE=1'b1.
  - Register address constants: ADDR_EN_OUT_7_0=0x00, ADDR_EN_OUT_15_8=0x01, ADDR_EN_PWM_7_0=0x02, ADDR_EN_PWM_15_8=0x03, ADDR_PWM_DUTY=0x04.
- Sub-module spi_rr_arb2: 2-way round-robin arbiter. Inputs: req[1:0], accept. Output: one-hot grant[1:0]. It holds the last-grant pointer internally.
- The top level holds the FSM, phase counter, bit index, frame shift register and output registers.

## Test plan
- Single write on port 0 (addr 0x04, data 0xA5), checked with the peripheral model attached:
  - sdi bits observed at sclk rising edges are 0x84A5.
  - 16 rising edges occur, and ncs is low for 132 cycles.
  - pwm_duty_cycle = 0xA5 after ncs rises.
  - done pulses with done_id=0 at cycle 141.
- Both ports valid in the same cycle (port 0 writing 0x00←0xFF, port 1 writing 0x01←0x0F):
  - Port 0 is served first, then port 1.
  - Both registers update in that order.
- Port 0 held continuously valid while port 1 requests mid-transaction: the next grant goes to port 1, showing round-robin with no starvation.
- rst_n asserted at the 8th sclk rising edge:
  - ncs=1, sclk=0, busy=0 within the reset assertion; no done pulse.
  - After release, a new write (0x02←0x3C) completes correctly.
- CLK_DIV=3, CS_GAP=4, ten back-to-back writes cycling addresses 0x00–0x04 (0x04 carries 0x80): every peripheral register matches the last value written to it.
- Write to unmapped address 0x07 (data 0x55): the frame is sent (0x8755), done pulses, and no peripheral register changes.
